// File: rtl/noc_vc_arbiter.sv
// noc_vc_arbiter: wormhole round-robin arbiter that merges NUM_PORTS
// first-word-fall-through sources onto one router input port. It tracks
// downstream credit per VC and registers one flit per cycle.
module noc_vc_arbiter #(
    parameter int NUM_PORTS    = 4,
    parameter int WIDTH        = 16,
    parameter int NUM_VC       = 2,
    parameter int DEPTH_PER_VC = 10,
    parameter int VC_W         = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_PORTS*WIDTH-1:0] i_data_in,
    input  logic [NUM_PORTS-1:0]       i_ready_in,
    input  logic [NUM_PORTS*VC_W-1:0]  i_vc_in,
    output logic [NUM_PORTS-1:0]       o_read_en,
    output logic [WIDTH-1:0]           o_flit_out,
    output logic                       o_flit_valid,
    output logic [VC_W-1:0]            o_flit_vc,
    input  logic [NUM_VC-1:0]          o_credits_in,
    output logic                       o_proto_err,
    output logic                       o_credit_err
);

    localparam int CW = $clog2(DEPTH_PER_VC + 1);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [CW-1:0] CMAX = CW'(DEPTH_PER_VC);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state;
    logic [PW-1:0]   rr;
    logic [PW-1:0]   owner;
    logic [VC_W-1:0] lock_vc;
    logic [CW-1:0]   credit [NUM_VC];

    logic [VC_W-1:0]      vc_of [NUM_PORTS];
    logic [NUM_PORTS-1:0] elig;
    logic                 gnt_vld;
    logic [PW-1:0]        gnt_idx;
    logic [WIDTH-1:0]     gnt_flit;
    logic [VC_W-1:0]      gnt_vc;
    logic                 gnt_head;
    logic                 gnt_tail;
    logic                 consume;

    function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
        next_port = PW'((int'(p) + 1) % NUM_PORTS);
    endfunction

    // Eligibility, round-robin / locked-owner selection and the pop strobe.
    always_comb begin
        int idx;
        idx      = 0;
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            vc_of[i] = (state == LOCKED) ? lock_vc : i_vc_in[i*VC_W +: VC_W];
            elig[i]  = i_ready_in[i] && (credit[vc_of[i]] != '0);
        end
        if (state == LOCKED) begin
            if (elig[owner]) begin
                gnt_vld = 1'b1;
                gnt_idx = owner;
            end
        end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = (int'(rr) + k) % NUM_PORTS;
                if (!gnt_vld && elig[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = PW'(idx);
                end
            end
        end
        if (rst) gnt_vld = 1'b0;
        gnt_flit = i_data_in[int'(gnt_idx)*WIDTH +: WIDTH];
        gnt_vc   = vc_of[gnt_idx];
        gnt_head = gnt_flit[WIDTH-1];
        gnt_tail = gnt_flit[WIDTH-2];
        // A stray non-head flit in IDLE is popped but never forwarded.
        consume  = gnt_vld && ((state == LOCKED) || gnt_head);
        o_read_en = '0;
        if (gnt_vld) o_read_en[gnt_idx] = 1'b1;
    end

    // Per-VC credit counters; simultaneous grant and return cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VC; v++) credit[v] <= CMAX;
            o_credit_err <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (o_credits_in[v] && !(consume && gnt_vc == VC_W'(v))) begin
                    if (credit[v] == CMAX) o_credit_err <= 1'b1;
                    else                   credit[v] <= credit[v] + 1'b1;
                end else if (!o_credits_in[v] && consume && gnt_vc == VC_W'(v)) begin
                    credit[v] <= credit[v] - 1'b1;
                end
            end
        end
    end

    // Wormhole FSM, rr pointer and registered flit outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr           <= '0;
            owner        <= '0;
            lock_vc      <= '0;
            o_flit_out   <= '0;
            o_flit_valid <= 1'b0;
            o_flit_vc    <= '0;
            o_proto_err  <= 1'b0;
        end else begin
            o_flit_valid <= consume;
            if (consume) begin
                o_flit_out <= gnt_flit;
                o_flit_vc  <= gnt_vc;
            end
            if (gnt_vld) begin
                case (state)
                    IDLE: begin
                        if (!gnt_head) begin
                            o_proto_err <= 1'b1;
                            rr          <= next_port(gnt_idx);
                        end else if (gnt_tail) begin
                            rr <= next_port(gnt_idx);
                        end else begin
                            state   <= LOCKED;
                            owner   <= gnt_idx;
                            lock_vc <= gnt_vc;
                        end
                    end
                    LOCKED: begin
                        if (gnt_tail) begin
                            state <= IDLE;
                            rr    <= next_port(owner);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_noc_vc_arbiter.sv
// Directed bench for noc_vc_arbiter: per-port FWFT source queues feed the
// DUT, and each check compares against hand-derived values.
module tb_noc_vc_arbiter;

    localparam int NP = 4;
    localparam int W  = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [NP*W-1:0] i_data_in;
    logic [NP-1:0]   i_ready_in;
    logic [NP-1:0]   i_vc_in;
    logic [NP-1:0]   o_read_en;
    logic [W-1:0]    o_flit_out;
    logic            o_flit_valid;
    logic [0:0]      o_flit_vc;
    logic [1:0]      o_credits_in;
    logic            o_proto_err;
    logic            o_credit_err;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] q [NP][$];
    logic [0:0]   pvc [NP];

    noc_vc_arbiter dut (
        .clk(clk), .rst(rst),
        .i_data_in(i_data_in), .i_ready_in(i_ready_in), .i_vc_in(i_vc_in),
        .o_read_en(o_read_en), .o_flit_out(o_flit_out),
        .o_flit_valid(o_flit_valid), .o_flit_vc(o_flit_vc),
        .o_credits_in(o_credits_in),
        .o_proto_err(o_proto_err), .o_credit_err(o_credit_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            i_ready_in[p]        = (q[p].size() != 0);
            i_data_in[p*W +: W]  = (q[p].size() != 0) ? q[p][0] : '0;
            i_vc_in[p]           = pvc[p];
        end
    endtask

    // Advance one clock; pops whatever the DUT strobed just before the edge.
    task automatic cyc();
        logic [NP-1:0] rd;
        logic [W-1:0]  dmy;
        #2;
        rd = o_read_en;
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++)
            if (rd[p] && q[p].size() != 0) dmy = q[p].pop_front();
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        o_credits_in = '0;
        for (int p = 0; p < NP; p++) begin
            q[p].delete();
            pvc[p] = 1'b0;
        end
        drive();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        o_credits_in = '0;
        for (int p = 0; p < NP; p++) pvc[p] = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk("rst_valid", o_flit_valid, 0);
        chk("rst_out", o_flit_out, 0);
        chk("rst_vc", o_flit_vc, 0);
        chk("rst_rden", o_read_en, 0);
        chk("rst_cred0", int'(dut.credit[0]), 10);
        chk("rst_cred1", int'(dut.credit[1]), 10);

        // Three-flit packet on VC1 from port 0
        q[0].push_back(16'h8000); q[0].push_back(16'h0001); q[0].push_back(16'h4002);
        pvc[0] = 1'b1;
        drive();
        #1 chk("t1_rden_h", o_read_en, 1);
        cyc();
        chk("t1_v0", o_flit_valid, 1);
        chk("t1_d0", o_flit_out, 16'h8000);
        chk("t1_vc0", o_flit_vc, 1);
        #1 chk("t1_rden_b", o_read_en, 1);
        cyc();
        chk("t1_d1", o_flit_out, 16'h0001);
        chk("t1_v1", o_flit_valid, 1);
        cyc();
        chk("t1_d2", o_flit_out, 16'h4002);
        chk("t1_v2", o_flit_valid, 1);
        chk("t1_vc2", o_flit_vc, 1);
        cyc();
        chk("t1_v3", o_flit_valid, 0);
        chk("t1_cred1", int'(dut.credit[1]), 7);
        chk("t1_cred0", int'(dut.credit[0]), 10);

        // Round robin over four single-flit packets
        do_reset();
        for (int p = 0; p < NP; p++) q[p].push_back(16'hC000 + 16'(p));
        drive();
        for (int p = 0; p < NP; p++) begin
            #1 chk($sformatf("t2_rden%0d", p), o_read_en, 1 << p);
            cyc();
            chk($sformatf("t2_d%0d", p), o_flit_out, 16'hC000 + p);
        end
        q[1].push_back(16'hC011); q[0].push_back(16'hC010);
        drive();
        #1 chk("t2_rr_wrap", o_read_en, 1);
        cyc();
        cyc();
        chk("t2_d_p1", o_flit_out, 16'hC011);

        // Wormhole lock holds port 2 off until port 1's tail
        do_reset();
        q[1].push_back(16'h8011);
        q[2].push_back(16'hC020);
        drive();
        #1 chk("t3_rden_h", o_read_en, 2);
        cyc();
        chk("t3_d_h", o_flit_out, 16'h8011);
        #1 chk("t3_stall0", o_read_en, 0);
        cyc();
        chk("t3_stall_v", o_flit_valid, 0);
        #1 chk("t3_stall1", o_read_en, 0);
        q[1].push_back(16'h0012); q[1].push_back(16'h4013);
        drive();
        #1 chk("t3_rden_b", o_read_en, 2);
        cyc();
        chk("t3_d_b", o_flit_out, 16'h0012);
        #1 chk("t3_rden_t", o_read_en, 2);
        cyc();
        chk("t3_d_t", o_flit_out, 16'h4013);
        #1 chk("t3_rden_p2", o_read_en, 4);
        cyc();
        chk("t3_d_p2", o_flit_out, 16'hC020);
        chk("t3_v_p2", o_flit_valid, 1);

        // Drain VC0, then a single return re-enables one grant a cycle later
        do_reset();
        for (int i = 0; i < 11; i++) q[0].push_back(16'hC000 + 16'(i));
        drive();
        for (int i = 0; i < 10; i++) begin
            #1 chk($sformatf("t4_rden%0d", i), o_read_en, 1);
            cyc();
        end
        chk("t4_d9", o_flit_out, 16'hC009);
        chk("t4_cred0", int'(dut.credit[0]), 0);
        #1 chk("t4_empty_rden", o_read_en, 0);
        cyc();
        chk("t4_stall_v", o_flit_valid, 0);
        o_credits_in = 2'b01;
        #1 chk("t4_ret_rden", o_read_en, 0);
        cyc();
        o_credits_in = 2'b00;
        #1 chk("t4_post_rden", o_read_en, 1);
        cyc();
        chk("t4_post_v", o_flit_valid, 1);
        chk("t4_post_d", o_flit_out, 16'hC00A);

        // Grant + return cancel; overflow saturates and flags
        do_reset();
        for (int i = 0; i < 5; i++) q[0].push_back(16'hC000);
        drive();
        repeat (5) cyc();
        chk("t5_cred5", int'(dut.credit[0]), 5);
        q[0].push_back(16'hC005);
        drive();
        o_credits_in = 2'b01;
        cyc();
        o_credits_in = 2'b00;
        chk("t5_cancel", int'(dut.credit[0]), 5);
        chk("t5_cancel_v", o_flit_valid, 1);
        chk("t5_noerr", o_credit_err, 0);
        do_reset();
        o_credits_in = 2'b01;
        cyc();
        o_credits_in = 2'b00;
        chk("t5_sat", int'(dut.credit[0]), 10);
        chk("t5_cerr", o_credit_err, 1);
        chk("t5_perr", o_proto_err, 0);

        // Headless flit in IDLE, then reset mid-packet
        do_reset();
        q[0].push_back(16'h0005);
        drive();
        #1 chk("t6_rden", o_read_en, 1);
        cyc();
        chk("t6_v", o_flit_valid, 0);
        chk("t6_perr", o_proto_err, 1);
        chk("t6_cred0", int'(dut.credit[0]), 10);
        q[0].push_back(16'h8000); q[0].push_back(16'h0001);
        drive();
        cyc();
        cyc();
        chk("t6_mid_d", o_flit_out, 16'h0001);
        do_reset();
        chk("t6_rst_v", o_flit_valid, 0);
        chk("t6_rst_d", o_flit_out, 0);
        chk("t6_rst_perr", o_proto_err, 0);
        chk("t6_rst_cerr", o_credit_err, 0);
        chk("t6_rst_cred0", int'(dut.credit[0]), 10);
        chk("t6_rst_cred1", int'(dut.credit[1]), 10);
        q[0].push_back(16'h0007);
        drive();
        #1 chk("t6_idle_rden", o_read_en, 1);
        cyc();
        chk("t6_idle_perr", o_proto_err, 1);
        chk("t6_idle_v", o_flit_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
